// File: rtl/exmem_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register: bubble instruction,
// stage state encoding and the validity gate applied to control bits.
package exmem_reg_pkg;

  // Instruction word placed in the stage on reset, flush or an invalid capture.
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

  // Number of gated control bits: mem_write, mem_read, mem_to_reg, reg_write, dump.
  localparam int CTRL_BITS = 5;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // A control bit may only reach the MEM stage if its instruction is real.
  function automatic logic [CTRL_BITS-1:0] gate_ctrl(input logic [CTRL_BITS-1:0] ctrl,
                                                     input logic valid);
    return ctrl & {CTRL_BITS{valid}};
  endfunction

endpackage

// File: rtl/exmem_reg_dffw.sv
// Width-parameterised enable flop with synchronous active-high reset.
module dffw #(
  parameter int W = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled, hold otherwise; reset has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/exmem_reg.sv
// EX/MEM pipeline register with stall, bubble insertion and a halt state
// entered once a valid dump instruction has been captured.
module exmem_reg
  import exmem_reg_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [15:0]      instr_in,
  input  logic [WIDTH-1:0] alu_out_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [WIDTH-1:0] pc_inc_in,
  input  logic [2:0]       wr_reg_in,
  input  logic             mem_write_in,
  input  logic             mem_read_in,
  input  logic             mem_to_reg_in,
  input  logic             reg_write_in,
  input  logic             dump_in,
  output logic [15:0]      instr_out,
  output logic [WIDTH-1:0] alu_out_out,
  output logic [WIDTH-1:0] B_out,
  output logic [WIDTH-1:0] pc_inc_out,
  output logic [2:0]       wr_reg_out,
  output logic             mem_write_out,
  output logic             mem_read_out,
  output logic             mem_to_reg_out,
  output logic             reg_write_out,
  output logic             dump_out,
  output logic             valid_out,
  output logic             halted
);

  state_t state;
  state_t state_next;

  logic        is_halted;
  logic        capture;
  logic        data_load;
  logic        ctrl_load;
  logic [15:0] instr_d;
  logic [5:0]  ctrl_d;
  logic [5:0]  ctrl_q;

  // Decide which fields load this edge and what the instruction/control fields receive.
  always_comb begin
    is_halted = (state == HALTED);
    capture   = ~is_halted & ~flush & en;
    data_load = capture;
    ctrl_load = ~is_halted & (flush | en);
    instr_d   = NOP_INSTR;
    ctrl_d    = 6'b000000;
    if (flush) begin
      instr_d = NOP_INSTR;
      ctrl_d  = 6'b000000;
    end else begin
      instr_d = valid_in ? instr_in : NOP_INSTR;
      ctrl_d  = {valid_in,
                 gate_ctrl({mem_write_in, mem_read_in, mem_to_reg_in,
                            reg_write_in, dump_in}, valid_in)};
    end
  end

  // Next-state logic: a captured valid dump freezes the stage until reset.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (capture && valid_in && dump_in) begin
          state_next = HALTED;
        end else begin
          state_next = RUN;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  assign halted = (state == HALTED);

  dffw #(.W(16), .RST_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .rst(rst), .en(ctrl_load), .d(instr_d), .q(instr_out)
  );

  dffw #(.W(6), .RST_VAL(6'b000000)) u_ctrl (
    .clk(clk), .rst(rst), .en(ctrl_load), .d(ctrl_d), .q(ctrl_q)
  );

  dffw #(.W(WIDTH), .RST_VAL({WIDTH{1'b0}})) u_alu (
    .clk(clk), .rst(rst), .en(data_load), .d(alu_out_in), .q(alu_out_out)
  );

  dffw #(.W(WIDTH), .RST_VAL({WIDTH{1'b0}})) u_b (
    .clk(clk), .rst(rst), .en(data_load), .d(B_in), .q(B_out)
  );

  dffw #(.W(WIDTH), .RST_VAL({WIDTH{1'b0}})) u_pc (
    .clk(clk), .rst(rst), .en(data_load), .d(pc_inc_in), .q(pc_inc_out)
  );

  dffw #(.W(3), .RST_VAL(3'b000)) u_wr_reg (
    .clk(clk), .rst(rst), .en(data_load), .d(wr_reg_in), .q(wr_reg_out)
  );

  assign valid_out      = ctrl_q[5];
  assign mem_write_out  = ctrl_q[4];
  assign mem_read_out   = ctrl_q[3];
  assign mem_to_reg_out = ctrl_q[2];
  assign reg_write_out  = ctrl_q[1];
  assign dump_out       = ctrl_q[0];

endmodule

// File: tb/tb_exmem_reg.sv
// Self-checking bench for exmem_reg: behavioural model plus directed literal checks
// followed by randomized traffic.
module tb_exmem_reg;

  localparam int W = 16;
  localparam logic [15:0] NOP = 16'h0800;

  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [15:0] instr_in = 16'h0000;
  logic [W-1:0] alu_out_in = '0, B_in = '0, pc_inc_in = '0;
  logic [2:0] wr_reg_in = 3'd0;
  logic mem_write_in = 1'b0, mem_read_in = 1'b0, mem_to_reg_in = 1'b0;
  logic reg_write_in = 1'b0, dump_in = 1'b0;

  logic [15:0] instr_out;
  logic [W-1:0] alu_out_out, B_out, pc_inc_out;
  logic [2:0] wr_reg_out;
  logic mem_write_out, mem_read_out, mem_to_reg_out, reg_write_out, dump_out;
  logic valid_out, halted;

  int n_cmp = 0;
  int n_err = 0;

  exmem_reg #(.WIDTH(W), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in),
    .instr_in(instr_in), .alu_out_in(alu_out_in), .B_in(B_in),
    .pc_inc_in(pc_inc_in), .wr_reg_in(wr_reg_in),
    .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .dump_in(dump_in),
    .instr_out(instr_out), .alu_out_out(alu_out_out), .B_out(B_out),
    .pc_inc_out(pc_inc_out), .wr_reg_out(wr_reg_out),
    .mem_write_out(mem_write_out), .mem_read_out(mem_read_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .dump_out(dump_out), .valid_out(valid_out), .halted(halted)
  );

  always #5 clk = ~clk;

  // Behavioural model of what the MEM stage must hold.
  typedef struct {
    logic [15:0] instr;
    logic [W-1:0] alu, b, pc;
    logic [2:0] wr;
    logic mw, mr, m2r, rw, dump, valid, halted;
  } stage_t;

  stage_t m;
  bit model_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one edge following the stage's priority rules.
  always @(posedge clk) begin
    if (rst) begin
      m.instr = NOP; m.alu = '0; m.b = '0; m.pc = '0; m.wr = 3'd0;
      m.mw = 0; m.mr = 0; m.m2r = 0; m.rw = 0; m.dump = 0; m.valid = 0;
      m.halted = 0;
      model_known = 1'b1;
    end else if (m.halted) begin
      // frozen
    end else if (flush) begin
      m.instr = NOP;
      m.mw = 0; m.mr = 0; m.m2r = 0; m.rw = 0; m.dump = 0; m.valid = 0;
    end else if (!en) begin
      // stall
    end else begin
      m.instr = valid_in ? instr_in : NOP;
      m.alu = alu_out_in; m.b = B_in; m.pc = pc_inc_in; m.wr = wr_reg_in;
      m.mw  = mem_write_in  && valid_in;
      m.mr  = mem_read_in   && valid_in;
      m.m2r = mem_to_reg_in && valid_in;
      m.rw  = reg_write_in  && valid_in;
      m.dump = dump_in && valid_in;
      m.valid = valid_in;
      if (valid_in && dump_in) m.halted = 1;
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (model_known) begin
      chk("instr_out", {16'h0, instr_out}, {16'h0, m.instr});
      chk("alu_out_out", {16'h0, alu_out_out}, {16'h0, m.alu});
      chk("B_out", {16'h0, B_out}, {16'h0, m.b});
      chk("pc_inc_out", {16'h0, pc_inc_out}, {16'h0, m.pc});
      chk("wr_reg_out", {29'h0, wr_reg_out}, {29'h0, m.wr});
      chk("ctrl", {26'h0, valid_out, mem_write_out, mem_read_out, mem_to_reg_out,
                   reg_write_out, dump_out},
                  {26'h0, m.valid, m.mw, m.mr, m.m2r, m.rw, m.dump});
      chk("halted", {31'h0, halted}, {31'h0, m.halted});
    end
  end

  // One clock edge, then settle past the falling-edge compare.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic rand_data();
    instr_in = 16'($urandom); alu_out_in = W'($urandom); B_in = W'($urandom);
    pc_inc_in = W'($urandom); wr_reg_in = 3'($urandom);
    mem_write_in = 1'($urandom); mem_read_in = 1'($urandom);
    mem_to_reg_in = 1'($urandom); reg_write_in = 1'($urandom);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_instr"}, {16'h0, instr_out}, 32'h0000_0800);
    chk({tag, "_ctrl"}, {26'h0, valid_out, mem_write_out, mem_read_out,
                         mem_to_reg_out, reg_write_out, dump_out}, 32'h0);
    chk({tag, "_data"}, {alu_out_out | B_out | pc_inc_out, 13'h0, wr_reg_out}, 32'h0);
    chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
  endtask

  initial begin
    // Reset for one edge, then stall.
    #2;
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b0; rand_data(); tick();
    chk_reset_state("reset");

    // Plain valid capture.
    en = 1'b1; valid_in = 1'b1; instr_in = 16'hD8A4; alu_out_in = 16'h1234;
    B_in = 16'h00AA; pc_inc_in = 16'h0042; wr_reg_in = 3'd5;
    mem_write_in = 0; mem_read_in = 0; mem_to_reg_in = 0; reg_write_in = 1; dump_in = 0;
    tick();
    chk("cap_instr", {16'h0, instr_out}, 32'h0000_D8A4);
    chk("cap_alu", {16'h0, alu_out_out}, 32'h0000_1234);
    chk("cap_wr", {29'h0, wr_reg_out}, 32'd5);
    chk("cap_vr", {30'h0, valid_out, reg_write_out}, 32'd3);

    // Stall three cycles with changing inputs.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data(); valid_in = 1'($urandom); tick();
      chk("stall_instr", {16'h0, instr_out}, 32'h0000_D8A4);
      chk("stall_alu", {16'h0, alu_out_out}, 32'h0000_1234);
      chk("stall_rw", {31'h0, reg_write_out}, 32'd1);
    end

    // Flush while stalled.
    flush = 1'b1; en = 1'b0; valid_in = 1'b1; mem_write_in = 1'b1; alu_out_in = 16'hBEEF;
    tick();
    chk("flush_instr", {16'h0, instr_out}, 32'h0000_0800);
    chk("flush_mw_v", {30'h0, mem_write_out, valid_out}, 32'd0);
    chk("flush_alu", {16'h0, alu_out_out}, 32'h0000_1234);

    // Invalid capture gates all control, including dump.
    flush = 1'b0; en = 1'b1; valid_in = 1'b0; reg_write_in = 1; mem_write_in = 1; dump_in = 1;
    instr_in = 16'h5555;
    tick();
    chk("inv_ctrl", {29'h0, reg_write_out, mem_write_out, dump_out}, 32'd0);
    chk("inv_halted", {31'h0, halted}, 32'd0);
    chk("inv_instr", {16'h0, instr_out}, 32'h0000_0800);

    // Read and write together are passed through.
    valid_in = 1'b1; dump_in = 1'b0; mem_write_in = 1; mem_read_in = 1;
    tick();
    chk("rw_both", {30'h0, mem_write_out, mem_read_out}, 32'd3);

    // Flush beats a dump capture in the same cycle.
    flush = 1'b1; en = 1'b1; valid_in = 1'b1; dump_in = 1'b1;
    tick();
    chk("flushdump", {30'h0, dump_out, halted}, 32'd0);

    // Valid dump halts; stage then frozen regardless of flush/en.
    flush = 1'b0; en = 1'b1; valid_in = 1'b1; dump_in = 1'b1; instr_in = 16'h0000;
    tick();
    chk("dump_dh", {30'h0, dump_out, halted}, 32'd3);
    chk("dump_instr", {16'h0, instr_out}, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      rand_data(); flush = i[0]; en = 1'b1; valid_in = 1'b1; dump_in = 1'($urandom);
      tick();
      chk("frozen_instr", {16'h0, instr_out}, 32'h0000_0000);
      chk("frozen_dhv", {29'h0, dump_out, halted, valid_out}, 32'd7);
    end
    flush = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; en = 1'b0; tick();
    chk_reset_state("unhalt");

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      rst      = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 10);
      en       = ($urandom_range(0, 99) < 75);
      valid_in = ($urandom_range(0, 99) < 80);
      dump_in  = ($urandom_range(0, 99) < 3);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
